// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ctrl_unit multi-cycle control FSM.
// Optional JMP support is enabled by defining CTRL_JUMP_EN.
package ctrl_pkg;

    // Explicit encodings: these values are what state_out exposes.
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        STORE  = 4'd4,
        LOAD_A = 4'd5,
        LOAD_B = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
`ifdef CTRL_JUMP_EN
        HALT   = 4'd9,
        JUMP   = 4'd10
`else
        HALT   = 4'd9
`endif
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;

    // State entered after DECODE; NOOP and unknown opcodes go straight back to FETCH.
    function automatic state_t decode_next(input logic [3:0] opcode);
        state_t nxt;
        case (opcode)
            OP_STORE: nxt = STORE;
            OP_LOAD:  nxt = LOAD_A;
            OP_ADD:   nxt = ADD;
            OP_SUB:   nxt = SUB;
            OP_HALT:  nxt = HALT;
`ifdef CTRL_JUMP_EN
            OP_JMP:   nxt = JUMP;
`endif
            default:  nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_unit_decoder.sv
// Purely combinational Moore output decode: (state, IR) -> datapath controls.
// Nothing here depends on the live instruction bus, only on the registered IR.
module ctrl_unit_decoder
    import ctrl_pkg::*;
#(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
) (
    input  state_t              state,
    input  logic [15:0]         ir,
    output logic [DADDR_W-1:0]  d_addr,
    output logic                d_wr,
    output logic                rf_w_en,
    output logic [RADDR_W-1:0]  rf_w_addr,
    output logic [RADDR_W-1:0]  rf_ra_addr,
    output logic [RADDR_W-1:0]  rf_rb_addr,
    output logic [2:0]          alu_s,
    output logic                rf_s,
    output logic                halted
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // through the block leaves a signal unassigned and no latch is inferred.
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_w_en    = 1'b0;
        rf_w_addr  = '0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s      = ALU_PASS_A;
        rf_s       = 1'b0;
        halted     = 1'b0;

        case (state)
            STORE: begin
                d_addr     = DADDR_W'(ir[11:4]);
                rf_ra_addr = RADDR_W'(ir[3:0]);
                d_wr       = 1'b1;
            end
            LOAD_A: begin
                d_addr = DADDR_W'(ir[11:4]);
            end
            LOAD_B: begin
                // Memory read issued in LOAD_A is valid now; steer it into Rd.
                d_addr    = DADDR_W'(ir[11:4]);
                rf_s      = 1'b1;
                rf_w_addr = RADDR_W'(ir[3:0]);
                rf_w_en   = 1'b1;
            end
            ADD, SUB: begin
                rf_ra_addr = RADDR_W'(ir[11:8]);
                rf_rb_addr = RADDR_W'(ir[7:4]);
                rf_w_addr  = RADDR_W'(ir[3:0]);
                alu_s      = (state == ADD) ? ALU_ADD : ALU_SUB;
                rf_w_en    = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: owns PC, IR and FSM state; outputs decoded from state+IR.
// Define CTRL_JUMP_EN to add the JMP instruction (opcode 0110) and its JUMP state.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         instr,
    output logic [PC_W-1:0]     pc_addr,
    output logic [DADDR_W-1:0]  d_addr,
    output logic                d_wr,
    output logic                rf_w_en,
    output logic [RADDR_W-1:0]  rf_w_addr,
    output logic [RADDR_W-1:0]  rf_ra_addr,
    output logic [RADDR_W-1:0]  rf_rb_addr,
    output logic [2:0]          alu_s,
    output logic                rf_s,
    output logic                halted,
    output logic [15:0]         ir_out,
    output logic [3:0]          state_out
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            INIT:   state_d = FETCH;
            FETCH: begin
                ir_d    = instr;
                pc_d    = pc_q + PC_W'(1);
                state_d = DECODE;
            end
            DECODE: state_d = decode_next(ir_q[15:12]);
            LOAD_A: state_d = LOAD_B;
            HALT:   state_d = HALT;
`ifdef CTRL_JUMP_EN
            JUMP: begin
                pc_d    = ir_q[PC_W-1:0];
                state_d = FETCH;
            end
`endif
            // STORE, LOAD_B, ADD, SUB (and the unused NOOP code) all finish here.
            default: state_d = FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    ctrl_unit_decoder #(
        .DADDR_W (DADDR_W),
        .RADDR_W (RADDR_W)
    ) u_decoder (
        .state      (state_q),
        .ir         (ir_q),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_w_en    (rf_w_en),
        .rf_w_addr  (rf_w_addr),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .rf_s       (rf_s),
        .halted     (halted)
    );

    assign pc_addr   = pc_q;
    assign ir_out    = ir_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: instruction-level reference model drives
// per-cycle expectations; directed programs plus randomized instruction streams.
module tb_ctrl_unit;

    localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_STORE = 4'd4, S_LOAD_A = 4'd5, S_LOAD_B = 4'd6,
                           S_ADD = 4'd7, S_SUB = 4'd8, S_HALT = 4'd9, S_JUMP = 4'd10;

    typedef struct packed {
        logic [3:0]  st;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        dwr;
        logic        wen;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        rfs;
        logic        halt;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instr;
    logic [7:0]  pc_addr, d_addr;
    logic        d_wr, rf_w_en, rf_s, halted;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_out;
    logic [2:0]  alu_s;
    logic [15:0] ir_out;

    logic [15:0] imem [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state: architectural PC and IR.
    logic [7:0]  mpc;
    logic [15:0] mir;

    always #5 clk = ~clk;

    assign instr = imem[pc_addr];

    ctrl_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .pc_addr    (pc_addr),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_w_en    (rf_w_en),
        .rf_w_addr  (rf_w_addr),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .rf_s       (rf_s),
        .halted     (halted),
        .ir_out     (ir_out),
        .state_out  (state_out)
    );

    function automatic obs_t sample();
        obs_t o;
        o.st = state_out;  o.pc = pc_addr;   o.ir = ir_out;     o.da = d_addr;
        o.dwr = d_wr;      o.wen = rf_w_en;  o.wa = rf_w_addr;  o.ra = rf_ra_addr;
        o.rb = rf_rb_addr; o.alu = alu_s;    o.rfs = rf_s;      o.halt = halted;
        return o;
    endfunction

    // Expected outputs for a state with no strobes and zeroed addresses.
    function automatic obs_t idle(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        e.pc = mpc;
        e.ir = mir;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input obs_t e);
        check(tag, 64'(sample()), 64'(e));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mpc = '0;
        mir = '0;
        #1 check_cycle("reset_hold", idle(S_INIT));
        @(negedge clk);
        reset_n = 1'b1;
        check_cycle("init", idle(S_INIT));
        step();
    endtask

    // Execute one instruction at the model level and compare every cycle of it.
    task automatic run_instr(input string tag, output bit hit_halt);
        obs_t e;
        logic [3:0] op;
        hit_halt = 1'b0;
        check_cycle({tag, ".fetch"}, idle(S_FETCH));
        step();
        mir = imem[mpc];
        mpc = mpc + 8'd1;
        check_cycle({tag, ".decode"}, idle(S_DECODE));
        step();
        op = mir[15:12];
        case (op)
            4'h1: begin
                e = idle(S_STORE);
                e.da = mir[11:4]; e.ra = mir[3:0]; e.dwr = 1'b1;
                check_cycle({tag, ".store"}, e);
                step();
            end
            4'h2: begin
                e = idle(S_LOAD_A);
                e.da = mir[11:4];
                check_cycle({tag, ".load_a"}, e);
                step();
                e = idle(S_LOAD_B);
                e.da = mir[11:4]; e.rfs = 1'b1; e.wa = mir[3:0]; e.wen = 1'b1;
                check_cycle({tag, ".load_b"}, e);
                step();
            end
            4'h3, 4'h4: begin
                e = idle(op == 4'h3 ? S_ADD : S_SUB);
                e.ra = mir[11:8]; e.rb = mir[7:4]; e.wa = mir[3:0]; e.wen = 1'b1;
                e.alu = (op == 4'h3) ? 3'b001 : 3'b010;
                check_cycle({tag, ".alu"}, e);
                step();
            end
            4'h5: begin
                for (int k = 0; k < 6; k++) begin
                    e = idle(S_HALT);
                    e.halt = 1'b1;
                    check_cycle({tag, ".halt"}, e);
                    step();
                end
                hit_halt = 1'b1;
            end
`ifdef CTRL_JUMP_EN
            4'h6: begin
                check_cycle({tag, ".jump"}, idle(S_JUMP));
                step();
                mpc = mir[7:0];
            end
`endif
            default: ;
        endcase
    endtask

    task automatic run_prog(input string tag, input int max_instr, input bit expect_halt);
        bit h;
        h = 1'b0;
        for (int i = 0; i < max_instr && !h; i++)
            run_instr(tag, h);
        if (expect_halt)
            check({tag, ".reached_halt"}, 64'(h), 64'd1);
    endtask

    task automatic fill_random(input bit allow_jmp);
        logic [31:0] r;
        logic [3:0]  op;
        for (int a = 0; a < 256; a++) begin
            r  = $urandom;
            op = r[15:12];
            if (op == 4'h5 || (!allow_jmp && op == 4'h6))
                op = 4'h3;
            imem[a] = {op, r[27:16]};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t e;

        // All-NOOP program: PC steps 0,1,2,... every two cycles with no strobes.
        for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
        do_reset();
        run_prog("noop", 4, 1'b0);

        // Directed program: ADD, LOAD, STORE, JMP (NOOP when disabled), HALT.
        imem[0]    = 16'h3125;
        imem[1]    = 16'h21A3;
        imem[2]    = 16'h1FF7;
        imem[3]    = 16'h6042;
        imem[4]    = 16'h5000;
        imem[8'h42] = 16'h5000;
        do_reset();
        run_prog("directed", 10, 1'b1);

        // Random stream without jumps runs past PC=0xFF, exercising wrap to 0.
        fill_random(1'b0);
        do_reset();
        run_prog("wrap", 300, 1'b0);

        // Random stream including opcode 0110.
        fill_random(1'b1);
        do_reset();
        run_prog("rand", 150, 1'b0);

        // Reset asserted in LOAD_A aborts the load asynchronously.
        for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
        imem[0] = 16'h21A3;
        do_reset();
        check_cycle("abort.fetch", idle(S_FETCH));
        step();
        mir = imem[0];
        mpc = 8'd1;
        check_cycle("abort.decode", idle(S_DECODE));
        step();
        e = idle(S_LOAD_A);
        e.da = 8'h1A;
        check_cycle("abort.load_a", e);
        reset_n = 1'b0;
        mpc = '0;
        mir = '0;
        #1 check_cycle("abort.async", idle(S_INIT));
        @(posedge clk);
        #1 check_cycle("abort.no_write", idle(S_INIT));
        do_reset();
        run_prog("post_abort", 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
Multi-cycle control FSM for the 16-bit processor; the stage directly upstream of the 16x16 register file. Owns the PC and IR and fetches from instruction memory. Decodes each instruction and drives register-file addresses/write enable, the data-memory address/write strobe, ALU select and the write-back mux select. Executes one instruction per 2–4 cycles.

Parameters:
PC_W, 8, program counter / instruction memory address width
DADDR_W, 8, data memory address width
RADDR_W, 4, register file address width (16 registers)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset_n  in  1  asynchronous active-low reset
instr  in  16  instruction memory read data; combinational function of pc_addr
pc_addr  out  PC_W  instruction memory address (PC register)
d_addr  out  DADDR_W  data memory address
d_wr  out  1  data memory write strobe (data = register file port A)
rf_w_en  out  1  register file write enable
rf_w_addr  out  RADDR_W  register file write address
rf_ra_addr  out  RADDR_W  register file read address A
rf_rb_addr  out  RADDR_W  register file read address B
alu_s  out  3  ALU op select
rf_s  out  1  write-back mux: 0 = ALU result, 1 = data memory read
halted  out  1  high while in HALT
ir_out  out  16  current IR (debug)
state_out  out  4  current FSM state encoding (debug)

Behaviour:
- Clock clk; reset reset_n is asynchronous, active-low. Reset forces state INIT, PC=0, IR=0. All outputs derive from that: every strobe 0, every address 0, halted 0, alu_s = PASS_A (000), rf_s = 0.
- All outputs are Moore outputs: combinational from state+IR only. No combinational path from instr to any output.
- Instruction format:
  - opcode = IR[15:12]
  - NOOP 0000
  - STORE 0001: d_addr = IR[11:4], src Ra = IR[3:0]
  - LOAD 0010: d_addr = IR[11:4], dest Rd = IR[3:0]
  - ADD 0011 / SUB 0100: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0]
  - HALT 0101
  - Any other opcode executes as NOOP.
- States and transitions:
  - INIT → FETCH.
  - FETCH: IR <= instr, PC <= PC+1 (mod 2^PC_W; 255 wraps to 0). → DECODE.
  - DECODE: branch on opcode to NOOP→FETCH, STORE, LOAD_A, ADD, SUB, or HALT.
  - STORE: d_addr = IR[11:4], rf_ra_addr = IR[3:0], d_wr = 1 for exactly this cycle. → FETCH.
  - LOAD_A: d_addr = IR[11:4] (synchronous memory read issued). → LOAD_B.
  - LOAD_B: d_addr held, rf_s = 1, rf_w_addr = IR[3:0], rf_w_en = 1. → FETCH.
  - ADD / SUB: rf_ra_addr = IR[11:8], rf_rb_addr = IR[7:4], alu_s = ADD (001) or SUB (010), rf_s = 0, rf_w_addr = IR[3:0], rf_w_en = 1. → FETCH.
  - HALT: halted = 1, all strobes 0. Remains in HALT until reset.
- Cycles per instruction: NOOP 2, STORE/ADD/SUB 3, LOAD 4.
- rf_w_en and d_wr are never high together and never high for more than one cycle per instruction.
- Rd equal to Ra or Rb is legal: the register file samples its inputs on the same edge.
- Reset asserted mid-instruction aborts immediately; no write strobe completes after reset assertion.
- Outside the states listed above, addresses hold at IR-independent 0.

Optional Feature:
Macro CTRL_JUMP_EN.
- Defined: opcode 0110 = JMP, target = IR[7:0]. Flow is DECODE → JUMP; in JUMP, PC <= IR[PC_W-1:0], no strobes. → FETCH. CPI 3.
- Undefined: 0110 decodes as NOOP and the JUMP state does not exist.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum: INIT, FETCH, DECODE, NOOP, STORE, LOAD_A, LOAD_B, ADD, SUB, HALT, JUMP; 4-bit encoding matches state_out.
  - opcode constants OP_NOOP…OP_JMP.
  - ALU select constants ALU_PASS_A=000, ALU_ADD=001, ALU_SUB=010.
- One natural sub-module: ctrl_decoder, purely combinational, mapping (state, IR) to all output signals. The top level holds the PC/IR/state registers.

Test Plan:
- Reset release with instr=0x0000 → state_out INIT then FETCH; pc_addr increments 0,1,2 every 2 cycles; no strobes.
- instr=0x3125 (ADD) → in the ADD cycle: rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=5, alu_s=001, rf_s=0, rf_w_en=1 for one cycle; next state FETCH.
- instr=0x21A3 (LOAD) → d_addr=0x1A in LOAD_A and LOAD_B; rf_w_en=1, rf_s=1, rf_w_addr=3 only in LOAD_B; total 4 cycles.
- instr=0x1FF7 (STORE) → d_addr=0xFF, rf_ra_addr=7, d_wr=1 for one cycle, rf_w_en=0.
- instr=0x5000 (HALT) → halted=1 indefinitely and pc_addr frozen; assert reset_n=0 mid-LOAD_A → outputs 0 asynchronously, no write.
- PC=0xFF during FETCH → pc_addr becomes 0x00. With CTRL_JUMP_EN, instr=0x6042 → pc_addr=0x42 after the JUMP state.
